cpu_mem_ctrl: RTL

Single-port memory controller sitting directly downstream of the CPU top. It merges the CPU's instruction-fetch port and data port onto one backing-memory request/acknowledge bus and generates the CPU's `mem_valid` stall handshake. It keeps a one-entry fetch buffer and a bus-timeout watchdog, and can optionally post writes through a small write buffer.

---
 rtl/cpu_mem_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_ctrl.sv
// Single-port memory controller merging CPU fetch and data ports onto one req/ack bus.
// Define WRITE_BUFFER_EN to post stores through a WB_DEPTH-entry write FIFO.
module cpu_mem_ctrl #(
  parameter int TIMEOUT  = 16,
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_instr_addr,
  output logic [31:0] cpu_instr_data,
  output logic        cpu_instr_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wr_data,
  input  logic        cpu_mem_wr,
  input  logic        cpu_mem_rd,
  output logic [31:0] cpu_mem_rd_data,
  output logic        cpu_mem_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      ABORT_DATA = 32'hDEAD_BEEF;

  if (TIMEOUT < 1 || WB_DEPTH < 1) begin : g_bad_params
    $error("TIMEOUT and WB_DEPTH must both be at least 1");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]      tag;
  logic             tag_valid;
  logic             fetch_needed, busy, timeout, complete;
  logic [31:0]      rsp_data;
  logic             go_data, go_fetch, go_drain, wb_pop;
  logic [31:0]      req_addr, req_wdata;
  logic             req_we;

  assign fetch_needed    = !tag_valid || (tag != cpu_instr_addr);
  assign busy            = (state == DATA) || (state == FETCH);
  // An ack in the last watchdog cycle wins over the timeout.
  assign timeout         = busy && !mem_ack && (wd_cnt == CNT_LAST);
  assign complete        = busy && (mem_ack || timeout);
  assign rsp_data        = mem_ack ? mem_rdata : ABORT_DATA;
  assign cpu_instr_valid = tag_valid && (tag == cpu_instr_addr) && (state != FETCH);

`ifdef WRITE_BUFFER_EN
  localparam int               PTR_W    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WB_DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(WB_DEPTH);

  logic [31:0]      wb_addr [WB_DEPTH];
  logic [31:0]      wb_data [WB_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   wb_count;
  logic             wb_full, wb_empty, wb_push, wb_ack, rd_pending;

  assign wb_full    = (wb_count == CNT_FULL);
  assign wb_empty   = (wb_count == '0);
  // wb_ack marks the consumption cycle of a posted store; the held request is ignored then.
  assign wb_push    = cpu_mem_wr && !wb_ack && !wb_full && ((state == IDLE) || (state == FETCH));
  assign wb_pop     = complete && (state == DATA) && mem_we;
  assign rd_pending = cpu_mem_rd && !cpu_mem_wr && !wb_ack;

  // Reads drain the whole FIFO first so they observe every earlier store.
  assign go_data  = (state == IDLE) && rd_pending && wb_empty;
  assign go_drain = (state == IDLE) && !wb_empty && (rd_pending || !fetch_needed);
  assign go_fetch = (state == IDLE) && !rd_pending && fetch_needed;

  assign cpu_mem_valid = !(cpu_mem_rd || cpu_mem_wr) || (state == DONE) || wb_ack;

  // NOTE: FIFO storage is deliberately not reset; pointers and count alone define emptiness.
  always_ff @(posedge clk) begin
    if (wb_push) begin
      wb_addr[wr_ptr] <= cpu_mem_addr;
      wb_data[wr_ptr] <= cpu_mem_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
      wb_ack   <= 1'b0;
    end else begin
      wb_ack <= wb_push;
      if (wb_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (wb_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({wb_push, wb_pop})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: wb_count <= wb_count;
      endcase
    end
  end
`else
  assign wb_pop   = 1'b0;
  assign go_drain = 1'b0;
  assign go_data  = (state == IDLE) && (cpu_mem_rd || cpu_mem_wr);
  assign go_fetch = (state == IDLE) && !(cpu_mem_rd || cpu_mem_wr) && fetch_needed;

  assign cpu_mem_valid = !(cpu_mem_rd || cpu_mem_wr) || (state == DONE);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req_addr  = cpu_mem_addr;
    req_wdata = cpu_mem_wr_data;
    req_we    = cpu_mem_wr;
    if (go_fetch) begin
      req_addr = cpu_instr_addr;
      req_we   = 1'b0;
    end
`ifdef WRITE_BUFFER_EN
    if (go_drain) begin
      req_addr  = wb_addr[rd_ptr];
      req_wdata = wb_data[rd_ptr];
      req_we    = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (go_data || go_drain) state_next = DATA;
             else if (go_fetch)       state_next = FETCH;
      DATA:  if (complete) state_next = wb_pop ? IDLE : DONE;
      FETCH: if (complete) state_next = IDLE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      wd_cnt          <= '0;
      tag             <= '0;
      tag_valid       <= 1'b0;
      cpu_instr_data  <= '0;
      cpu_mem_rd_data <= '0;
      bus_err         <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && (state_next != IDLE)) begin
        mem_req   <= 1'b1;
        mem_we    <= req_we;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        wd_cnt    <= '0;
      end else if (complete) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        wd_cnt  <= '0;
      end else if (busy) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (complete && (state == DATA) && !mem_we) cpu_mem_rd_data <= rsp_data;
      if (complete && (state == FETCH)) begin
        cpu_instr_data <= rsp_data;
        tag            <= mem_addr;
        tag_valid      <= mem_ack;
      end
      if (timeout) bus_err <= 1'b1;
    end
  end

endmodule
